// File: rtl/ifq_pkg.sv
// Shared types and sizing helpers for the instruction-fetch queue.
package ifq_pkg;

    typedef enum logic {
        IFQ_IDLE,
        IFQ_RUN
    } ifq_state_t;

    localparam int IFQ_PC_W    = 11;
    localparam int IFQ_INSTR_W = 32;
    localparam int IFQ_DEPTH   = 4;

    function automatic int ifq_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int ifq_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of {pc, instr} entries; flush wins over push.
// Head outputs hold their last value while the buffer is empty.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter  int PC_W    = IFQ_PC_W,
    parameter  int INSTR_W = IFQ_INSTR_W,
    parameter  int DEPTH   = IFQ_DEPTH,
    localparam int PTR_W   = ifq_ptr_w(DEPTH),
    localparam int CNT_W   = ifq_cnt_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [PC_W-1:0]    push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic               pop,
    input  logic               flush,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output logic [PC_W-1:0]    head_pc,
    output logic [INSTR_W-1:0] head_instr
);

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PC_W-1:0]    hold_pc_q, hold_pc_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;

    logic wr_en;

    assign wr_en = push && !flush;
    assign empty = (count_q == '0);
    assign count = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_comb begin
        head_pc    = hold_pc_q;
        head_instr = hold_instr_q;
        if (!empty) begin
            head_pc    = pc_mem[rd_ptr_q];
            head_instr = instr_mem[rd_ptr_q];
        end
        hold_pc_d    = head_pc;
        hold_instr_d = head_instr;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr_q]    <= push_pc;
            instr_mem[wr_ptr_q] <= push_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Prefetching PC generator feeding a DEPTH-entry instruction queue,
// with redirect/halt flush and discard of in-flight RAM reads.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter  int PC_W    = IFQ_PC_W,
    parameter  int INSTR_W = IFQ_INSTR_W,
    parameter  int DEPTH   = IFQ_DEPTH,
    localparam int CNT_W   = ifq_cnt_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PC_W-1:0]    start_pc,
    input  logic               halt,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_rd,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    input  logic               out_ready,
    output logic               waiting,
    output logic [CNT_W-1:0]   count
);

    localparam int OCC_W = CNT_W + 1;

    ifq_state_t state_q, state_d;

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] tag_q, tag_d;
    logic            inflight_q, inflight_d;
    logic            kill_q, kill_d;

    logic             run;
    logic             pop;
    logic             flush;
    logic             issue;
    logic             push;
    logic             fifo_empty;
    logic [OCC_W-1:0] occ;

    assign run   = (state_q == IFQ_RUN);
    assign pop   = out_valid && out_ready;
    assign flush = run && (halt || redirect);

    // Occupancy after this cycle's pop, counting the read still in flight.
    assign occ   = OCC_W'(count) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign issue = run && !flush && (occ < OCC_W'(DEPTH));

    // A response is dropped if a flush lands on it or preceded it.
    assign push  = inflight_q && !kill_q && !flush;

    assign imem_rd   = issue;
    assign imem_addr = fetch_pc_q;
    assign out_valid = !fifo_empty;
    assign waiting   = !run;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        unique case (state_q)
            IFQ_IDLE: begin
                if (start) begin
                    state_d    = IFQ_RUN;
                    fetch_pc_d = start_pc;
                end
            end
            IFQ_RUN: begin
                if (halt) begin
                    state_d = IFQ_IDLE;
                end else if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (issue) begin
                    fetch_pc_d = fetch_pc_q + PC_W'(1);
                end
            end
            default: state_d = IFQ_IDLE;
        endcase
    end

    always_comb begin
        inflight_d = issue;
        tag_d      = issue ? fetch_pc_q : tag_q;
        kill_d     = kill_q;
        if (issue) begin
            kill_d = 1'b0;
        end else if (flush) begin
            kill_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IFQ_IDLE;
            fetch_pc_q <= '0;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
        end
    end

    ifq_fifo #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_pc    (tag_q),
        .push_instr (imem_data),
        .pop        (pop),
        .flush      (flush),
        .count      (count),
        .empty      (fifo_empty),
        .head_pc    (out_pc),
        .head_instr (out_instr)
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: directed scenarios plus random traffic
// checked against a stream-level model of the expected {pc, instr} order.
module tb_ifetch_queue;

    localparam int PC_W    = 11;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 3;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [PC_W-1:0]    start_pc;
    logic               halt;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               imem_rd;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic               out_ready;
    logic               waiting;
    logic [CNT_W-1:0]   count;

    ifetch_queue #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_pc    (start_pc),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_ready   (out_ready),
        .waiting     (waiting),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] pc);
        logic [31:0] h;
        h = {21'd0, pc} * 32'd2654435761;
        return h ^ 32'hE1A0_0000;
    endfunction

    // Synchronous instruction RAM: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= instr_of(imem_addr);
    end

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: after start/redirect the decoder must see an
    // unbroken run of consecutive PCs (mod 2^PC_W) until the next flush.
    bit              model_run;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] exp_q[$];

    task automatic refill(input logic [PC_W-1:0] pc);
        exp_q.delete();
        next_pc = pc;
    endtask

    always @(negedge clk) begin
        logic [PC_W-1:0] e;
        if (!rst_n) begin
            model_run = 1'b0;
            exp_q.delete();
        end else begin
            check("count_bound", 32'(count <= CNT_W'(DEPTH)), 32'd1);
            if (!model_run) begin
                check("idle_rd", 32'(imem_rd), 32'd0);
                check("idle_valid", 32'(out_valid), 32'd0);
                check("idle_waiting", 32'(waiting), 32'd1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 32'(out_pc), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc", 32'(out_pc), 32'(e));
                    check("out_instr", out_instr, instr_of(e));
                end
            end
            if (!model_run && start) begin
                model_run = 1'b1;
                refill(start_pc);
            end else if (model_run && halt) begin
                model_run = 1'b0;
                exp_q.delete();
            end else if (model_run && redirect) begin
                refill(redirect_pc);
            end
            while (model_run && exp_q.size() < 8) begin
                exp_q.push_back(next_pc);
                next_pc = next_pc + PC_W'(1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_halt();
        step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        @(negedge clk);
        check("halt_waiting", 32'(waiting), 32'd1);
        check("halt_count", 32'(count), 32'd0);
        check("halt_rd", 32'(imem_rd), 32'd0);
    endtask

    task automatic do_start(input logic [PC_W-1:0] pc, input logic rdy);
        step();
        start     = 1'b1;
        start_pc  = pc;
        out_ready = rdy;
        step();
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        start_pc    = '0;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        #3;
        check("rst_waiting", 32'(waiting), 32'd1);
        check("rst_rd", 32'(imem_rd), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pc", 32'(out_pc), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;

        // Streaming with decoder always ready.
        step();
        start     = 1'b1;
        start_pc  = 11'h010;
        out_ready = 1'b1;
        @(negedge clk);
        check("s1_idle_rd", 32'(imem_rd), 32'd0);
        step();
        start = 1'b0;
        @(negedge clk);
        check("s1_rd0", 32'(imem_rd), 32'd1);
        check("s1_addr0", 32'(imem_addr), 32'h010);
        step();
        @(negedge clk);
        check("s1_addr1", 32'(imem_addr), 32'h011);
        check("s1_valid_n1", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        check("s1_addr2", 32'(imem_addr), 32'h012);
        check("s1_valid_n2", 32'(out_valid), 32'd1);
        check("s1_pc_n2", 32'(out_pc), 32'h010);
        step();
        @(negedge clk);
        check("s1_pc_n3", 32'(out_pc), 32'h011);
        repeat (6) step();
        do_halt();
        repeat (3) begin
            step();
            @(negedge clk);
            check("halt_no_rd", 32'(imem_rd), 32'd0);
        end

        // Back-pressure until full, then drain.
        do_start(11'h010, 1'b0);
        repeat (8) step();
        @(negedge clk);
        check("full_count", 32'(count), 32'd4);
        check("full_rd", 32'(imem_rd), 32'd0);
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_head", 32'(out_pc), 32'h010);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("full_pop_issue", 32'(imem_rd), 32'd1);
        repeat (8) step();
        do_halt();

        // Redirect with three entries queued and one read in flight.
        do_start(11'h100, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (count == 3) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("redir_reach3", 32'(found), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 11'h200;
        @(negedge clk);
        check("redir_no_rd", 32'(imem_rd), 32'd0);
        step();
        redirect  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("redir_rd", 32'(imem_rd), 32'd1);
        check("redir_addr", 32'(imem_addr), 32'h200);
        check("redir_valid0", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        check("redir_valid1", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        check("redir_valid2", 32'(out_valid), 32'd1);
        check("redir_pc", 32'(out_pc), 32'h200);
        repeat (4) step();
        do_halt();

        // PC wrap at the top of the address space.
        do_start(11'h7FE, 1'b1);
        @(negedge clk);
        check("wrap_a0", 32'(imem_addr), 32'h7FE);
        step();
        @(negedge clk);
        check("wrap_a1", 32'(imem_addr), 32'h7FF);
        step();
        @(negedge clk);
        check("wrap_a2", 32'(imem_addr), 32'h000);
        step();
        @(negedge clk);
        check("wrap_a3", 32'(imem_addr), 32'h001);
        repeat (5) step();
        do_halt();

        // Asynchronous reset with a full queue.
        do_start(11'h040, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (count == 4) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("ar_full", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_waiting", 32'(waiting), 32'd1);
        check("ar_rd", 32'(imem_rd), 32'd0);
        check("ar_addr", 32'(imem_addr), 32'd0);
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_pc", 32'(out_pc), 32'd0);
        check("ar_instr", out_instr, 32'd0);
        check("ar_count", 32'(count), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step();
            out_ready   = ($urandom_range(0, 9) < 7);
            start       = ($urandom_range(0, 3) == 0);
            start_pc    = PC_W'($urandom);
            halt        = ($urandom_range(0, 49) == 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = PC_W'($urandom);
        end
        step();
        start    = 1'b0;
        halt     = 1'b0;
        redirect = 1'b0;
        do_halt();
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
